// File: rtl/morse_symbol_ctrl.sv
// Morse key timing controller: classifies each key-down as dot or dash, drives the
// symbol shift register one bit per press, and flags the inter-letter gap.
module morse_symbol_ctrl #(
    parameter int DASH_TICKS  = 3,
    parameter int GAP_TICKS   = 3,
    parameter int MAX_SYMBOLS = 5,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       key,
    output logic       shift,
    output logic       SI,
    output logic [2:0] sym_count,
    output logic       letter_done,
    output logic       overflow,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating tick count; long presses pin at full scale and still read as dash.
    assign cnt_inc = (tick && !(&cnt)) ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shift       <= 1'b0;
            SI          <= 1'b0;
            sym_count   <= 3'd0;
            letter_done <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            shift       <= 1'b0;
            letter_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key) begin
                        state     <= S_PRESS;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        sym_count <= 3'd0;
                        overflow  <= 1'b0;
                    end
                end
                S_PRESS: begin
                    if (!key) begin
                        // The release-cycle tick is deliberately ignored: classify on cnt.
                        if (sym_count < 3'(MAX_SYMBOLS)) begin
                            shift     <= 1'b1;
                            SI        <= (cnt >= CNT_W'(DASH_TICKS));
                            sym_count <= sym_count + 3'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_GAP: begin
                    if (key) begin
                        state <= S_PRESS;
                        cnt   <= '0;
                    end else if (cnt_inc >= CNT_W'(GAP_TICKS)) begin
                        state       <= S_DONE;
                        letter_done <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/morse_symbol_ctrl.md
Name: morse_symbol_ctrl

Overview:
Timing controller that turns a debounced Morse key into dot/dash symbols and sequences the 5-bit symbol shift register. It measures each key-down duration in timebase ticks and issues one registered shift pulse per symbol, with SI=0 for a dot and SI=1 for a dash. It counts symbols per letter, detects the inter-letter gap, and pulses letter_done so the downstream lookup can latch the register contents and sym_count.

Parameters:
DASH_TICKS, 3, press duration in ticks at or above which a symbol is a dash; below is a dot.
GAP_TICKS, 3, key-up duration in ticks that ends a letter.
MAX_SYMBOLS, 5, maximum symbols per letter; must match the shift register depth.
CNT_W, 8, width of the tick counter; the counter saturates at 2^CNT_W-1.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
tick  input  1  one-cycle timebase strobe (unit time).
key  input  1  debounced key level, synchronous to clk, 1 = pressed.
shift  output  1  one-cycle shift enable to the symbol shift register.
SI  output  1  serial symbol bit: 0 = dot, 1 = dash; valid when shift=1.
sym_count  output  3  symbols captured in the current or last letter (0..MAX_SYMBOLS).
letter_done  output  1  one-cycle pulse: letter complete; sym_count and overflow are valid.
overflow  output  1  sticky flag: the letter had more than MAX_SYMBOLS presses.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, reset_n=0): state IDLE; tick counter=0; shift=0, SI=0, sym_count=0, letter_done=0, overflow=0, busy=0. Reset mid-letter discards the letter with no letter_done pulse.
- All outputs are registered. Decisions use the key value sampled at the rising clk edge.
- IDLE: when key=1 is sampled, go to PRESS; clear the counter, clear sym_count and clear overflow.
- PRESS: on each cycle with tick=1, the counter increments (saturating).
  - When key=0 is sampled, compute dash = (counter >= DASH_TICKS), using the registered counter value. A tick in the same cycle as the release is not counted.
  - If sym_count < MAX_SYMBOLS: shift=1 and SI=dash for exactly the next cycle; sym_count increments.
  - Otherwise: no shift; overflow is set and sym_count is held.
  - Then go to GAP and clear the counter.
- GAP: on each cycle with tick=1, the counter increments.
  - If key=1 is sampled, go to PRESS and clear the counter. The letter continues.
  - Else, if the counter reaches GAP_TICKS, go to DONE.
  - If key=1 and the threshold are reached in the same cycle, the key wins and the FSM goes to PRESS.
- DONE: letter_done=1 for one cycle, then go to IDLE. sym_count and overflow hold until the next key press from IDLE.
- A zero-tick press (release before any tick) is a dot. A press longer than the counter range classifies as a dash.
- shift is never asserted in consecutive cycles. At most one shift occurs per key-down.
- busy=1 in PRESS, GAP and DONE.

Test Plan:
1. Reset, then press key for 1 tick and release; wait 3 ticks -> one shift pulse with SI=0; letter_done pulses once with sym_count=1, overflow=0.
2. Press for 4 ticks, gap 1 tick, press 1 tick, gap 1 tick, press 4 ticks, then idle 3 ticks -> three shift pulses with SI=1,0,1; letter_done with sym_count=3.
3. Six presses of 1 tick each, separated by 1-tick gaps -> five shift pulses only; letter_done with sym_count=5, overflow=1; the next press clears overflow and sym_count.
4. DASH boundary: press for exactly 2 ticks -> SI=0. Press for exactly 3 ticks -> SI=1. Release in the same cycle as the 3rd tick -> SI=0.
5. In GAP with counter=2, assert key in the same cycle as the 3rd tick -> no letter_done; FSM returns to PRESS and sym_count keeps counting.
6. Assert reset_n=0 during PRESS after 2 symbols -> all outputs 0 asynchronously; no letter_done; the next letter starts with sym_count=0.
